// File: rtl/uart_cmd_tx.sv
// ---------------------------------------------------------------------------
// uart_cmd_tx
//   Serialises the 8-bit device command byte onto the UART tx line as 8N1
//   frames. A frame is sent when the byte changes, when the refresh timer
//   expires after a quiet period, or when send_req forces one. Triggers seen
//   while a frame is in flight collapse into a single follow-up frame.
//
//   Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit
//   between the data bits and the stop bit (frame becomes 11 bit times).
//
// Ports
//   sys_clk    in   1  system clock
//   rst        in   1  asynchronous active-low reset
//   data_in    in   8  command byte to transmit
//   send_req   in   1  single-cycle pulse, forces a frame of current data_in
//   tx         out  1  UART serial line, idle high
//   busy       out  1  high from first start-bit cycle to last stop-bit cycle
//   tx_done    out  1  one-cycle pulse in the cycle after the last stop bit
//   frame_cnt  out 16  completed frames, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module uart_cmd_tx #(
  parameter int unsigned CLKS_PER_BIT   = 10417,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        send_req,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  // PARITY is only ever entered when the parity build option is enabled.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        last_sent_q, last_sent_d;
  logic              last_valid_q, last_valid_d;
  logic              pending_q, pending_d;
  logic [REF_W-1:0]  refresh_q, refresh_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic trigger;
  logic bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign trigger = !last_valid_q || (data_in != last_sent_q) ||
                   (refresh_q == REF_LAST) || send_req;

  always_comb begin
    // NOTE: every next-state signal is defaulted first so that no branch can
    // leave one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    last_sent_d  = last_sent_q;
    last_valid_d = last_valid_q;
    pending_d    = pending_q;
    refresh_d    = refresh_q;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    tx_d         = 1'b1;

    // Any trigger during a frame is remembered; a data change is compared
    // against last_sent again once the line is idle.
    if (state_q != IDLE && trigger) pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          state_d      = START;
          cnt_d        = '0;
          idx_d        = '0;
          data_d       = data_in;
          last_sent_d  = data_in;
          last_valid_d = 1'b1;
          pending_d    = 1'b0;
          refresh_d    = '0;
        end else if (refresh_q != REF_LAST) begin
          refresh_d = refresh_q + 1'b1;
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decoded from next-state values and registered, so
    // tx changes exactly on the edge that enters each bit and never glitches.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = ^data_d;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      last_sent_q  <= 8'h00;
      last_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      refresh_q    <= '0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      last_sent_q  <= last_sent_d;
      last_valid_q <= last_valid_d;
      pending_q    <= pending_d;
      refresh_q    <= refresh_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_tx
//   Self-checking bench for uart_cmd_tx with CLKS_PER_BIT=4 and
//   REFRESH_CYCLES=100. A frame-level model predicts tx/busy/tx_done/
//   frame_cnt every cycle; directed steps pin literal timing and data.
//   Cycle k is the interval after the k-th rising edge with rst high.
// ---------------------------------------------------------------------------
module tb_uart_cmd_tx;

  localparam int CPB     = 4;
  localparam int REFRESH = 100;
`ifdef UART_TX_PARITY_EN
  localparam int          NSLOT      = 11;
  localparam logic [7:0]  FIRST_BYTE = 8'h07;
  localparam logic [10:0] FIRST_BITS = 11'b110_0000_1110;
  localparam int          DONE1      = 45;
  localparam int          REF_START  = 145;
  localparam bit          PAR        = 1'b1;
`else
  localparam int          NSLOT      = 10;
  localparam logic [7:0]  FIRST_BYTE = 8'h85;
  localparam logic [10:0] FIRST_BITS = 11'b011_0000_1010;
  localparam int          DONE1      = 41;
  localparam int          REF_START  = 141;
  localparam bit          PAR        = 1'b0;
`endif
  localparam int FL = NSLOT * CPB;

  logic        sys_clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        send_req;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit running  = 1'b1;

  uart_cmd_tx #(
    .CLKS_PER_BIT   (CPB),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .data_in   (data_in),
    .send_req  (send_req),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .frame_cnt (frame_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d t=%0t: got %0h expected %0h", name, cyc, $time, act, exp);
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  // ---------------- frame-level reference model ----------------
  // Line level at position p of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    int slot;
    slot = p / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR && slot == 9) return ^b;
    return 1'b1;
  endfunction

  logic        m_busy, m_done, m_last_ok, m_pend;
  logic [7:0]  m_byte, m_last;
  logic [15:0] m_fc;
  int          m_pos, m_idle;
  logic        m_trig;
  logic [7:0]  started[$];

  assign m_trig = !m_last_ok || (data_in != m_last) || send_req || (m_idle == REFRESH - 1);

  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_last_ok <= 1'b0;
      m_pend    <= 1'b0;
      m_byte    <= 8'h00;
      m_last    <= 8'h00;
      m_fc      <= 16'h0;
      m_pos     <= 0;
      m_idle    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_trig) m_pend <= 1'b1;
        if (m_pos == FL - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_fc   <= m_fc + 16'd1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end else if (m_trig || m_pend) begin
        m_busy    <= 1'b1;
        m_pos     <= 0;
        m_byte    <= data_in;
        m_last    <= data_in;
        m_last_ok <= 1'b1;
        m_pend    <= 1'b0;
        m_idle    <= 0;
        started.push_back(data_in);
      end else if (m_idle < REFRESH - 1) begin
        m_idle <= m_idle + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (running) begin
      check("cmp_tx",        32'(tx),        32'(m_busy ? frame_bit(m_byte, m_pos) : 1'b1));
      check("cmp_busy",      32'(busy),      32'(m_busy));
      check("cmp_tx_done",   32'(tx_done),   32'(m_done));
      check("cmp_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [10:0] bits;
    int s2, s3, s4, s5;

    rst      = 1'b1;
    data_in  = FIRST_BYTE;
    send_req = 1'b0;
    #1 rst = 1'b0;
    #11;
    check("reset_tx",   32'(tx),        32'd1);
    check("reset_busy", 32'(busy),      32'd0);
    check("reset_done", 32'(tx_done),   32'd0);
    check("reset_fcnt", 32'(frame_cnt), 32'd0);
    #10 rst = 1'b1;
    #1;
    check("c0_tx_idle", 32'(tx), 32'd1);

    // First frame straight out of reset.
    bits = FIRST_BITS;
    for (int s = 0; s < NSLOT; s++) begin
      at_cycle(1 + s * CPB + 2);
      check("f1_slot_tx", 32'(tx),   32'(bits[s]));
      check("f1_busy",    32'(busy), 32'd1);
    end
    at_cycle(FL);
    check("f1_last_stop_busy", 32'(busy), 32'd1);
    at_cycle(DONE1);
    check("f1_done",   32'(tx_done),   32'd1);
    check("f1_idle",   32'(busy),      32'd0);
    check("f1_fcnt",   32'(frame_cnt), 32'd1);

    // Unchanged byte: refresh only after 100 idle cycles.
    at_cycle(REF_START - 1);
    check("ref_not_early_busy", 32'(busy),           32'd0);
    check("ref_not_early_tx",   32'(tx),             32'd1);
    check("ref_not_early_log",  32'(started.size()), 32'd1);
    at_cycle(REF_START);
    check("ref_start_tx",   32'(tx),             32'd0);
    check("ref_start_log",  32'(started.size()), 32'd2);
    check("ref_start_byte", 32'(started[1]),     32'(FIRST_BYTE));

    // Data change during bit 3 does not disturb the frame in flight.
    s2 = REF_START;
    at_cycle(s2 + 17);
    data_in = 8'h8A;
    at_cycle(s2 + 18);
    check("chg_bit3_old_data", 32'(tx), 32'd0);
    s3 = s2 + FL + 1;
    at_cycle(s3 - 1);
    check("gap_tx",   32'(tx),      32'd1);
    check("gap_busy", 32'(busy),    32'd0);
    check("gap_done", 32'(tx_done), 32'd1);
    at_cycle(s3);
    check("f3_start_tx",   32'(tx),             32'd0);
    check("f3_start_log",  32'(started.size()), 32'd3);
    check("f3_byte",       32'(started[2]),     32'h8A);
    check("f3_fcnt",       32'(frame_cnt),      32'd2);

    // Two forced sends plus a data change collapse to one follow-up frame.
    at_cycle(s3 + 10); send_req = 1'b1;
    at_cycle(s3 + 11); send_req = 1'b0;
    at_cycle(s3 + 20); send_req = 1'b1;
    at_cycle(s3 + 21); send_req = 1'b0;
    at_cycle(s3 + 25); data_in = 8'hA0;
    s4 = s3 + FL + 1;
    at_cycle(s4);
    check("f4_start_busy", 32'(busy),           32'd1);
    check("f4_log",        32'(started.size()), 32'd4);
    check("f4_byte",       32'(started[3]),     32'hA0);
    at_cycle(s4 + FL);
    check("f4_done", 32'(tx_done),   32'd1);
    check("f4_fcnt", 32'(frame_cnt), 32'd4);
    at_cycle(s4 + FL + 1);
    check("f4_single_followup_busy", 32'(busy),           32'd0);
    check("f4_single_followup_log",  32'(started.size()), 32'd4);

    // Forced frame, then abort with reset during bit 5.
    send_req = 1'b1;
    s5 = s4 + FL + 2;
    at_cycle(s5);
    send_req = 1'b0;
    check("f5_start_tx", 32'(tx), 32'd0);
    at_cycle(s5 + 25);
    #2 rst = 1'b0;
    #1;
    check("abort_tx",   32'(tx),        32'd1);
    check("abort_busy", 32'(busy),      32'd0);
    check("abort_done", 32'(tx_done),   32'd0);
    check("abort_fcnt", 32'(frame_cnt), 32'd0);
    @(negedge sys_clk);
    #2 rst = 1'b1;
    #1;
    check("post_rst_c0_tx", 32'(tx), 32'd1);
    at_cycle(1);
    check("post_rst_start_tx",   32'(tx),             32'd0);
    check("post_rst_start_busy", 32'(busy),           32'd1);
    check("post_rst_log",        32'(started.size()), 32'd6);
    check("post_rst_byte",       32'(started[5]),     32'hA0);
    at_cycle(DONE1);
    check("post_rst_done", 32'(tx_done),   32'd1);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
    at_cycle(DONE1 + 4);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_tx.md
Name: uart_cmd_tx

Overview:
- Transmit stage that serialises the 8-bit device command byte onto the UART tx line as 8N1 frames, for the simulated-device link.
- Sends a frame when the command byte changes, when a periodic refresh timer expires, or when a send is forced.
- Upstream is the command-byte assembly in the device top: {2'b10, destroy, place, moving_state[3:0]}. Downstream is the tx pin.

Parameters:
- CLKS_PER_BIT, 10417, sys_clk cycles per UART bit (100 MHz / 9600 baud); must be >= 2.
- REFRESH_CYCLES, 1000000, idle cycles after a frame starts before the unchanged byte is re-sent (10 ms); must be >= 1.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  8  command byte to transmit.
- send_req  input  1  single-cycle pulse; forces transmission of the current data_in.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse in the cycle after the last stop-bit cycle.
- frame_cnt  output  16  count of completed frames; wraps 16'hFFFF -> 16'h0000.

Behaviour:
- Reset (rst=0, async):
  - tx=1, busy=0, tx_done=0, frame_cnt=0.
  - State IDLE, refresh timer=0, pending=0, last_valid=0, last_sent=8'h00.
  - Asserting rst mid-frame aborts the frame immediately: tx returns high with no partial stop bit.
- Trigger, evaluated each cycle, true if any of:
  - last_valid==0;
  - data_in != last_sent;
  - refresh timer == REFRESH_CYCLES-1;
  - send_req==1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On trigger at cycle N: latch data_in into the shift register and last_sent; set last_valid=1; clear the refresh timer.
  - Enter START at N+1, so tx=0 and busy=1 at N+1 (one-cycle latency).
  - With no trigger, the refresh timer increments, saturating at REFRESH_CYCLES-1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index 0..7; after bit 7 expires, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - On the STOP->IDLE transition: tx_done=1 for one cycle and frame_cnt increments.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- data_in is sampled only at frame start. Changes mid-frame do not alter the frame in flight.
- Any trigger condition seen while busy sets pending=1. A data_in change is re-evaluated against last_sent at IDLE.
- If pending=1 or a trigger is present on entering IDLE, the next frame begins on the IDLE cycle: START follows in the next cycle.
  - Gap between back-to-back frames is exactly 1 idle-high cycle, in addition to the stop bit.
  - pending clears when the new frame starts.
- Several triggers during one frame collapse to a single follow-up frame carrying the latest data_in.
- The refresh timer does not count while busy. It restarts at 0 on every frame start.
- A bit counter (0..CLKS_PER_BIT-1) and bit index are internal and reset to 0 on each state entry.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 latched bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT; tx_done and frame_cnt timing shift accordingly.
- Not defined: no parity state, 8N1 exactly as above.

Test Plan:
- Use CLKS_PER_BIT=4 and REFRESH_CYCLES=100 for all scenarios.
- Reset release with data_in=8'h85:
  - tx goes low 1 cycle after the first clock edge with rst=1.
  - Bits seen on tx: 0 | 1,0,1,0,0,0,0,1 | 1, at 4 cycles each.
  - tx_done pulses at cycle 41; frame_cnt=1.
- Hold data_in=8'h85 constant after the first frame:
  - The next START begins 100 idle cycles after the previous frame start, with the same byte.
  - No frame is sent earlier.
- Change data_in 8'h85->8'h8A at bit 3 of a frame:
  - The current frame still sends 8'h85.
  - The next frame (8'h8A) starts with exactly one idle-high cycle after the stop bit.
- Pulse send_req twice and change data_in to 8'hA0 during one frame:
  - Exactly one follow-up frame, carrying 8'hA0; frame_cnt increments by 2 in total.
- Assert rst at bit 5 of a frame:
  - tx=1, busy=0, frame_cnt=0 immediately, with no clock required.
  - After release, a fresh frame is sent, because last_valid=0.
- With UART_TX_PARITY_EN defined, data_in=8'h07:
  - Parity bit 1 appears after bit 7; frame is 44 cycles; tx_done at cycle 45.
